// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared encodings and width helpers for the async_fifo write-port arbiter.
package fifo_arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping through ptr itself.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDXW = width_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  // One extra bit so base + offset (< 2*NREQ) never overflows before the modulo.
  localparam int unsigned SW = IDXW + 1;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SW-1:0]     base;
  logic [SW-1:0]     sum;

  always_comb begin
    dbl  = {req, req};
    base = SW'(ptr) + SW'(1);
    if (base >= SW'(NREQ)) base = base - SW'(NREQ);
    rot  = NREQ'(dbl >> base);
    any  = |req;
    sum  = base;
    // Scan from the top so the lowest rotated position wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) sum = base + SW'(k);
    end
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    idx = IDXW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of one async_fifo write port among NREQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNTW      = 16,
  localparam int unsigned IDXW     = width_of(NREQ),
  localparam int unsigned BCW      = width_of(BURST_MAX)
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  input  logic               full,
  output logic               w_en,
  output logic [DW-1:0]      data_in,
  output logic               gnt_valid,
  output logic [IDXW-1:0]    gnt_idx,
  output logic [CNTW-1:0]    wr_count
);

  logic [0:0]      state, state_nx;
  logic            gnt_valid_nx;
  logic [IDXW-1:0] gnt_idx_nx;
  logic [IDXW-1:0] last_ptr, last_ptr_nx;
  logic [BCW-1:0]  beat_cnt, beat_cnt_nx;
  logic [CNTW-1:0] wr_count_nx;

  logic [DW-1:0]   req_word [NREQ];
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] req_masked;
  logic [NREQ-1:0] pick_req;
  logic [IDXW-1:0] pick_ptr;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            holder_req;
  logic            beat;
  logic            burst_end;
  logic            rearb;

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_data[i*DW +: DW];
  end

  assign gnt_oh     = NREQ'(1) << gnt_idx;
  assign holder_req = req[gnt_idx];
  assign beat       = gnt_valid & holder_req & ~full;
  assign burst_end  = beat & (beat_cnt == BCW'(BURST_MAX - 1));
  assign rearb      = ~holder_req | burst_end;

  // A holder that still requests stays eligible, so a lone requester is re-granted.
  assign req_masked = holder_req ? req : (req & ~gnt_oh);
  assign pick_req   = (state == ST_BUSY) ? req_masked : req;
  assign pick_ptr   = (state == ST_BUSY) ? gnt_idx : last_ptr;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign w_en    = beat;
  assign ack     = beat ? gnt_oh : '0;
  assign data_in = req_word[gnt_idx];

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      last_ptr  <= IDXW'(NREQ - 1);
      beat_cnt  <= '0;
      wr_count  <= '0;
    end else begin
      state     <= state_nx;
      gnt_valid <= gnt_valid_nx;
      gnt_idx   <= gnt_idx_nx;
      last_ptr  <= last_ptr_nx;
      beat_cnt  <= beat_cnt_nx;
      wr_count  <= wr_count_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    gnt_valid_nx = gnt_valid;
    gnt_idx_nx   = gnt_idx;
    last_ptr_nx  = last_ptr;
    beat_cnt_nx  = beat_cnt;
    wr_count_nx  = beat ? (wr_count + CNTW'(1)) : wr_count;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nx     = ST_BUSY;
          gnt_valid_nx = 1'b1;
          gnt_idx_nx   = pick_idx;
          beat_cnt_nx  = '0;
        end
      end
      ST_BUSY: begin
        if (!rearb) begin
          if (beat) beat_cnt_nx = beat_cnt + BCW'(1);
        end else begin
          last_ptr_nx = gnt_idx;
          // Hand over in the same cycle so there is no bubble between bursts.
          if (pick_any) begin
            gnt_idx_nx  = pick_idx;
            beat_cnt_nx = '0;
          end else begin
            state_nx     = ST_IDLE;
            gnt_valid_nx = 1'b0;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester sources, expected beat queue, FIFO capture.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned BM   = 4;
  localparam int unsigned CNTW = 16;
  localparam int unsigned IDXW = 2;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   data;
  } beat_t;

  logic               wclk = 1'b0;
  logic               wrst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    ack;
  logic               full = 1'b0;
  logic               w_en;
  logic [DW-1:0]      data_in;
  logic               gnt_valid;
  logic [IDXW-1:0]    gnt_idx;
  logic [CNTW-1:0]    wr_count;

  logic [DW-1:0] src_q [NREQ][$];
  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [NREQ-1:0] en = '0;
  logic          full_drv = 1'b0;
  logic          wrst_drv = 1'b1;
  int            checks = 0;
  int            errors = 0;

  always #10 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .BURST_MAX(BM), .CNTW(CNTW)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .ack(ack),
    .full(full), .w_en(w_en), .data_in(data_in), .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx), .wr_count(wr_count)
  );

  function automatic logic [DW-1:0] dat(input int r, input int k);
    return DW'(r * 64 + k);
  endfunction

  task automatic load(input int r, input int n);
    for (int k = 0; k < n; k++) src_q[r].push_back(dat(r, k));
  endtask

  task automatic exp_beats(input int r, input int from, input int n);
    for (int k = from; k < from + n; k++) exp_q.push_back(beat_t'{IDXW'(r), dat(r, k)});
  endtask

  // One clock: drive at negedge, sample 1 ns later, score any beat against exp_q.
  task automatic cycle();
    logic [DW-1:0]   tmp;
    logic [NREQ-1:0] exp_ack;
    beat_t           e;
    @(negedge wclk);
    wrst = wrst_drv;
    full = full_drv;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = en[i] && (src_q[i].size() > 0);
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : DW'(0);
    end
    #1;
    if (w_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got idx %0d data %0h, required no beat", gnt_idx, data_in);
      end else begin
        e = exp_q.pop_front();
        exp_ack = '0;
        exp_ack[e.idx] = 1'b1;
        checks++;
        if (gnt_idx !== e.idx) begin
          errors++;
          $display("FAIL beat_idx: got %0d required %0d", gnt_idx, e.idx);
        end
        checks++;
        if (data_in !== e.data) begin
          errors++;
          $display("FAIL beat_data: got %0h required %0h", data_in, e.data);
        end
        checks++;
        if (ack !== exp_ack) begin
          errors++;
          $display("FAIL beat_ack: got %b required %b", ack, exp_ack);
        end
      end
      fifo_q.push_back(data_in);
      for (int i = 0; i < NREQ; i++)
        if (ack[i] && src_q[i].size() > 0) tmp = src_q[i].pop_front();
    end else begin
      checks++;
      if (ack !== '0) begin
        errors++;
        $display("FAIL idle_ack: got %b required 0", ack);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
    end
  endtask

  task automatic reset_dut();
    en = '0;
    full_drv = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    fifo_q.delete();
    wrst_drv = 1'b1;
    cycle();
    cycle();
    wrst_drv = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    for (int r = 0; r < NREQ; r++) load(r, 1);
    en = 4'b1111;
    wrst_drv = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("rst_w_en", 32'(w_en), 32'd0);
      chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
    end
    wrst_drv = 1'b0;
    for (int r = 0; r < NREQ; r++) exp_beats(r, 0, 1);
    cycle();
    chk("rel_w_en", 32'(w_en), 32'd0);
    chk("rel_gnt_valid", 32'(gnt_valid), 32'd0);
    cycle();
    chk("first_gnt_valid", 32'(gnt_valid), 32'd1);
    chk("first_w_en", 32'(w_en), 32'd1);
    drain(20);
  endtask

  task automatic test_all_stream();
    reset_dut();
    load(0, 5);
    for (int r = 1; r < NREQ; r++) load(r, 4);
    for (int r = 0; r < NREQ; r++) exp_beats(r, 0, 4);
    exp_beats(0, 4, 1);
    en = 4'b1111;
    cycle();
    chk("stream_idle", 32'(w_en), 32'd0);
    for (int c = 0; c < 16; c++) begin
      cycle();
      chk("stream_no_bubble", 32'(w_en), 32'd1);
    end
    cycle();
    chk("stream_wr_count16", 32'(wr_count), 32'd16);
    drain(10);
    cycle();
    chk("stream_wr_count17", 32'(wr_count), 32'd17);
  endtask

  task automatic test_lone();
    reset_dut();
    load(2, 10);
    exp_beats(2, 0, 10);
    en = 4'b0100;
    cycle();
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("lone_w_en", 32'(w_en), 32'd1);
    end
    cycle();
    chk("lone_end_w_en", 32'(w_en), 32'd0);
    chk("lone_end_valid", 32'(gnt_valid), 32'd1);
    cycle();
    chk("lone_idle_valid", 32'(gnt_valid), 32'd0);
    chk("lone_exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_full_stall();
    reset_dut();
    load(0, 4);
    load(1, 4);
    exp_beats(0, 0, 4);
    exp_beats(1, 0, 4);
    en = 4'b0011;
    cycle();
    cycle();
    cycle();
    full_drv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("full_w_en", 32'(w_en), 32'd0);
      chk("full_gnt_idx", 32'(gnt_idx), 32'd0);
      chk("full_gnt_valid", 32'(gnt_valid), 32'd1);
    end
    full_drv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("resume_w_en", 32'(w_en), 32'd1);
    end
    drain(4);
  endtask

  task automatic test_drop();
    reset_dut();
    load(0, 1);
    load(3, 3);
    exp_beats(0, 0, 1);
    exp_beats(3, 0, 3);
    en = 4'b1001;
    cycle();
    cycle();
    chk("drop_first_idx", 32'(gnt_idx), 32'd0);
    cycle();
    chk("drop_gap_w_en", 32'(w_en), 32'd0);
    cycle();
    chk("drop_switch_idx", 32'(gnt_idx), 32'd3);
    chk("drop_switch_w_en", 32'(w_en), 32'd1);
    cycle();
    cycle();
    cycle();
    chk("drop_tail_valid", 32'(gnt_valid), 32'd1);
    cycle();
    chk("drop_idle_valid", 32'(gnt_valid), 32'd0);
    chk("drop_exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_reset_mid();
    int pos;
    reset_dut();
    for (int r = 0; r < NREQ; r++) load(r, 4);
    exp_beats(0, 0, 3);
    en = 4'b1111;
    cycle();
    cycle();
    cycle();
    wrst_drv = 1'b1;
    cycle();
    wrst_drv = 1'b0;
    cycle();
    chk("midrst_valid", 32'(gnt_valid), 32'd0);
    chk("midrst_w_en", 32'(w_en), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    exp_beats(0, 3, 1);
    for (int r = 1; r < NREQ; r++) exp_beats(r, 0, 4);
    cycle();
    chk("midrst_restart_idx", 32'(gnt_idx), 32'd0);
    drain(40);
    chk("fifo_size", 32'(fifo_q.size()), 32'd16);
    for (int r = 0; r < NREQ; r++) begin
      pos = 0;
      foreach (fifo_q[j]) begin
        if (32'(fifo_q[j][7:6]) == 32'(r)) begin
          chk("fifo_order", 32'(fifo_q[j]), 32'(dat(r, pos)));
          pos++;
        end
      end
      chk("fifo_count_per_req", 32'(pos), 32'd4);
    end
  endtask

  initial begin
    test_reset();
    test_all_stream();
    test_lone();
    test_full_stall();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

endmodule
